convolution_3x3: RTL and testbench

//  Streaming 3x3 2-D convolution (cross-correlation, kernel not flipped) over one raster-order image.

---
 rtl/convolution_3x3.sv | 259 +++++++++++++++++++++++++
 tb/tb_convolution_3x3.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/convolution_3x3.sv
// -----------------------------------------------------------------------------
// convolution_3x3
//
// Streaming 3x3 valid-mode 2-D convolution (cross-correlation, kernel not
// flipped) over one raster-order image. Unsigned pixels are multiplied by a
// loadable signed 3x3 kernel. The block emits one result per complete 3x3
// window, so a frame yields (IMG_W-2) x (IMG_H-2) results. This is the first
// feature-extraction stage of the CNN datapath.
//
// Ports
//   clk         in   1       single clock, rising edge
//   rst         in   1       synchronous active-high reset (kernel is kept)
//   coef_we     in   1       kernel write strobe
//   coef_addr   in   4       kernel index row*3+col, 9..15 ignored
//   coef_data   in   COEF_W  signed coefficient
//   pix_valid   in   1       pix_in valid; always accepted
//   pix_in      in   PIX_W   unsigned pixel, raster order
//   conv_valid  out  1       conv_out valid this cycle
//   conv_out    out  ACC_W   signed result; holds when conv_valid=0
//   frame_done  out  1       pulse with the last result of a frame
//
// Pipeline (edge N = edge that accepts a window-completing pixel)
//   edge N   : line buffers and window registers shift in the pixel
//   edge N+1 : nine products registered
//   edge N+2 : adder tree result registered on conv_out
// -----------------------------------------------------------------------------
module convolution_3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_in,
    output logic                     conv_valid,
    output logic signed [ACC_W-1:0]  conv_out,
    output logic                     frame_done
);

    // Product width: zero-extended pixel (PIX_W+1 bits signed) times coefficient.
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Full-precision signed product of an unsigned pixel and a signed coefficient.
    function automatic logic signed [PROD_W-1:0] mac_product(
        input logic [PIX_W-1:0]         pix,
        input logic signed [COEF_W-1:0] coef
    );
        logic signed [PROD_W-1:0] px;
        logic signed [PROD_W-1:0] cf;
        px = $signed({{(PROD_W - PIX_W){1'b0}}, pix});
        cf = $signed({{(PROD_W - COEF_W){coef[COEF_W-1]}}, coef});
        return px * cf;
    endfunction

    // Sign-extend one product to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return $signed({{(ACC_W - PROD_W){p[PROD_W-1]}}, p});
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------

    // Kernel, indexed [row][col]. Deliberately not touched by rst so that a
    // preloaded or written kernel survives a reset.
    logic signed [COEF_W-1:0] filter [0:2][0:2];

    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;

    // r_lb_prev holds the previous image row, r_lb_prev2 the row before that.
    logic [PIX_W-1:0]         r_lb_prev  [0:IMG_W-1];
    logic [PIX_W-1:0]         r_lb_prev2 [0:IMG_W-1];

    // r_win[0][0] is the top-left pixel of the current window.
    logic [PIX_W-1:0]         r_win  [0:2][0:2];
    logic signed [PROD_W-1:0] r_prod [0:2][0:2];

    logic                     r_s0_valid;
    logic                     r_s0_last;
    logic                     r_s1_valid;
    logic                     r_s1_last;

    logic                     r_conv_valid;
    logic signed [ACC_W-1:0]  r_conv_out;
    logic                     r_frame_done;

    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_win_done;
    logic                     w_frame_last;

    // -------------------------------------------------------------------------
    // Kernel write port
    // -------------------------------------------------------------------------

    // Kernel write; reset wins over a concurrent write, addresses 9..15 do nothing.
    always_ff @(posedge clk) begin
        if (!rst && coef_we) begin
            case (coef_addr)
                4'd0:    filter[0][0] <= coef_data;
                4'd1:    filter[0][1] <= coef_data;
                4'd2:    filter[0][2] <= coef_data;
                4'd3:    filter[1][0] <= coef_data;
                4'd4:    filter[1][1] <= coef_data;
                4'd5:    filter[1][2] <= coef_data;
                4'd6:    filter[2][0] <= coef_data;
                4'd7:    filter[2][1] <= coef_data;
                4'd8:    filter[2][2] <= coef_data;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Raster position
    // -------------------------------------------------------------------------

    // Row/column counters of the next pixel; advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Window completion is decided from the position of the incoming pixel;
    // requiring col>=2 stops windows that would straddle a row wrap.
    always_comb begin
        w_win_done   = 1'b0;
        w_frame_last = 1'b0;
        if (pix_valid) begin
            w_win_done   = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
            w_frame_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
        end else begin
            w_win_done   = 1'b0;
            w_frame_last = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers and window
    // -------------------------------------------------------------------------

    // Line buffers and window shift. Contents are never cleared: the row/col
    // gating above guarantees stale data never reaches a valid result.
    always_ff @(posedge clk) begin
        if (!rst && pix_valid) begin
            r_lb_prev2[r_col] <= r_lb_prev[r_col];
            r_lb_prev[r_col]  <= pix_in;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb_prev2[r_col];
            r_win[1][2] <= r_lb_prev[r_col];
            r_win[2][2] <= pix_in;
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline control
    // -------------------------------------------------------------------------

    // Valid/last tokens travelling alongside the data; reset discards in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s0_valid <= w_win_done;
            r_s0_last  <= w_frame_last;
            r_s1_valid <= r_s0_valid;
            r_s1_last  <= r_s0_last;
        end
    end

    // -------------------------------------------------------------------------
    // Multiply stage
    // -------------------------------------------------------------------------

    // Nine products, sampled from the kernel as it stands on this cycle.
    always_ff @(posedge clk) begin
        if (r_s0_valid) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_prod[r][c] <= mac_product(r_win[r][c], filter[r][c]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accumulate stage
    // -------------------------------------------------------------------------

    // Adder tree over the sign-extended products; no rounding or saturation.
    always_comb begin
        w_sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_sum = w_sum + sext_prod(r_prod[r][c]);
            end
        end
    end

    // Output registers; conv_out holds its last value between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_valid <= 1'b0;
            r_conv_out   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_conv_valid <= r_s1_valid;
            r_frame_done <= r_s1_last;
            if (r_s1_valid) begin
                r_conv_out <= w_sum;
            end else begin
                r_conv_out <= r_conv_out;
            end
        end
    end

    assign conv_valid = r_conv_valid;
    assign conv_out   = r_conv_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_convolution_3x3.sv
// Testbench for convolution_3x3: a 4x4 and a 5x5 instance. Drivers push
// hand-computed expected results (value, frame_done, arrival time) into
// per-instance queues; monitors pop and compare whenever conv_valid is seen.
module tb_convolution_3x3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              a_coef_we, b_coef_we;
    logic [3:0]        a_coef_addr, b_coef_addr;
    logic [7:0]        a_coef_data, b_coef_data;
    logic              a_pix_valid, b_pix_valid;
    logic [7:0]        a_pix_in, b_pix_in;
    logic              a_conv_valid, b_conv_valid;
    logic signed [19:0] a_conv_out, b_conv_out;
    logic              a_frame_done, b_frame_done;

    int checks = 0;
    int errors = 0;
    int exp_vals [0:8];

    typedef struct {
        int     val;
        bit     last;
        longint t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    convolution_3x3 #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .COEF_W(8), .ACC_W(20)) u4 (
        .clk(clk), .rst(rst),
        .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
        .pix_valid(a_pix_valid), .pix_in(a_pix_in),
        .conv_valid(a_conv_valid), .conv_out(a_conv_out), .frame_done(a_frame_done)
    );

    convolution_3x3 #(.IMG_W(5), .IMG_H(5), .PIX_W(8), .COEF_W(8), .ACC_W(20)) u5 (
        .clk(clk), .rst(rst),
        .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
        .pix_valid(b_pix_valid), .pix_in(b_pix_in),
        .conv_valid(b_conv_valid), .conv_out(b_conv_out), .frame_done(b_frame_done)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor for the 4x4 instance.
    always @(negedge clk) begin
        if (a_conv_valid === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL u4_unexpected actual=%0d required=no result", a_conv_out);
            end else begin
                ea = qa.pop_front();
                if (a_conv_out !== 20'(ea.val) || a_frame_done !== ea.last || $time != ea.t) begin
                    errors++;
                    $display("FAIL u4_result actual=%0d fd=%0b t=%0t required=%0d fd=%0b t=%0d",
                             a_conv_out, a_frame_done, $time, ea.val, ea.last, ea.t);
                end
            end
        end else if (a_frame_done !== 1'b0 && rst === 1'b0) begin
            checks++;
            errors++;
            $display("FAIL u4_fd_alone actual=%b required=0", a_frame_done);
        end
    end

    // Monitor for the 5x5 instance.
    always @(negedge clk) begin
        if (b_conv_valid === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL u5_unexpected actual=%0d required=no result", b_conv_out);
            end else begin
                eb = qb.pop_front();
                if (b_conv_out !== 20'(eb.val) || b_frame_done !== eb.last || $time != eb.t) begin
                    errors++;
                    $display("FAIL u5_result actual=%0d fd=%0b t=%0t required=%0d fd=%0b t=%0d",
                             b_conv_out, b_frame_done, $time, eb.val, eb.last, eb.t);
                end
            end
        end else if (b_frame_done !== 1'b0 && rst === 1'b0) begin
            checks++;
            errors++;
            $display("FAIL u5_fd_alone actual=%b required=0", b_frame_done);
        end
    end

    task automatic write_coef(input bit sel, input int a, input int d);
        if (!sel) begin
            a_coef_we = 1'b1; a_coef_addr = 4'(a); a_coef_data = 8'(d);
        end else begin
            b_coef_we = 1'b1; b_coef_addr = 4'(a); b_coef_data = 8'(d);
        end
        @(negedge clk);
        a_coef_we = 1'b0;
        b_coef_we = 1'b0;
    endtask

    task automatic load_all(input bit sel, input int d);
        for (int a = 0; a < 9; a++) write_coef(sel, a, d);
    endtask

    // Sends one frame; on each window-completing pixel the next hand-computed
    // value from exp_vals is queued with its required arrival time.
    task automatic send_frame(input bit sel, input int w, input int h, input bit konst, input int max_gap);
        int   idx;
        exp_t e;
        idx = 0;
        for (int k = 0; k < w * h; k++) begin
            if (!sel) begin
                a_pix_valid = 1'b1; a_pix_in = konst ? 8'd255 : 8'(k);
            end else begin
                b_pix_valid = 1'b1; b_pix_in = konst ? 8'd255 : 8'(k);
            end
            @(posedge clk);
            if ((k / w) >= 2 && (k % w) >= 2) begin
                e.val  = exp_vals[idx];
                e.last = (k == w * h - 1);
                e.t    = longint'($time) + 25;
                idx++;
                if (!sel) qa.push_back(e);
                else      qb.push_back(e);
            end
            @(negedge clk);
            a_pix_valid = 1'b0;
            b_pix_valid = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_coef_we = 1'b0; a_coef_addr = 4'd0; a_coef_data = 8'd0;
        b_coef_we = 1'b0; b_coef_addr = 4'd0; b_coef_data = 8'd0;
        a_pix_valid = 1'b0; a_pix_in = 8'd0;
        b_pix_valid = 1'b0; b_pix_in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_conv_valid", a_conv_valid, 0);
        chk("rst_conv_out", a_conv_out, 0);
        chk("rst_frame_done", a_frame_done, 0);
        chk("rst_u5_conv_valid", b_conv_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // 5x5 ramp, centre tap only: result is the centre pixel.
        for (int a = 0; a < 9; a++) write_coef(1'b1, a, (a == 4) ? 1 : 0);
        exp_vals = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        send_frame(1'b1, 5, 5, 1'b0, 0);
        drain();
        chk("u5_filter_11", u5.filter[1][1], 1);
        chk("u5_filter_00", u5.filter[0][0], 0);

        // 4x4 ramp, all-ones kernel.
        load_all(1'b0, 1);
        exp_vals = '{45, 54, 81, 90, 0, 0, 0, 0, 0};
        send_frame(1'b0, 4, 4, 1'b0, 0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_conv_valid", a_conv_valid, 0);
        chk("hold_conv_out", a_conv_out, 90);

        // Same frame with random idle gaps; latency is checked by the monitor.
        send_frame(1'b0, 4, 4, 1'b0, 3);
        drain();

        // Reset mid-frame while a result is in flight; concurrent pixel and
        // kernel write must both be ignored.
        for (int k = 0; k < 11; k++) begin
            a_pix_valid = 1'b1; a_pix_in = 8'(k);
            @(negedge clk);
        end
        rst = 1'b1;
        a_pix_valid = 1'b1; a_pix_in = 8'd200;
        a_coef_we = 1'b1; a_coef_addr = 4'd0; a_coef_data = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        a_pix_valid = 1'b0;
        a_coef_we = 1'b0;
        chk("midrst_conv_valid", a_conv_valid, 0);
        chk("midrst_frame_done", a_frame_done, 0);
        chk("midrst_conv_out", a_conv_out, 0);
        repeat (4) @(negedge clk);

        // Out-of-range kernel addresses are ignored.
        for (int a = 9; a < 16; a++) write_coef(1'b0, a, 8'h55);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                chk($sformatf("filter_%0d%0d", r, c), u4.filter[r][c], 1);

        send_frame(1'b0, 4, 4, 1'b0, 0);
        drain();

        // Most negative kernel on saturated pixels, then all -1.
        load_all(1'b0, 8'h80);
        exp_vals = '{-293760, -293760, -293760, -293760, 0, 0, 0, 0, 0};
        send_frame(1'b0, 4, 4, 1'b1, 0);
        drain();
        load_all(1'b0, 8'hFF);
        exp_vals = '{-2295, -2295, -2295, -2295, 0, 0, 0, 0, 0};
        send_frame(1'b0, 4, 4, 1'b1, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
